exe_muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit with integrated HI/LO registers for the EXE stage. It replaces the fixed 32-bit MULTDIV + HILO pair with a configurable-width datapath. The multiplier is pipelined with programmable depth and the divider is iterative radix-2. The unit has an explicit request handshake, a pipeline stall output, flush-cancel, and optional multiply-accumulate.

---
 rtl/exe_muldiv_unit.sv | 249 ++++++++++++++++++++++++
 tb/tb_exe_muldiv_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/exe_muldiv_unit.sv
// exe_muldiv_unit
// Multi-cycle multiply/divide unit with architectural HI/LO registers for the
// EXE stage. Multiply runs through a MUL_STAGES-deep product pipeline; divide
// is an iterative radix-2 restoring divider followed by one sign-fix cycle.
//
// Optional feature macro: MDU_ACCUM_EN
//   defined   -> MADD/MADDU/MSUB/MSUBU accumulate into {hi,lo}
//   undefined -> ops 5..8 behave as NOP, no accumulate adder is built
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   flush                 cancels in-flight op, drops a same-cycle request
//   req_valid/op/a/b      operation request from EXE (sampled in IDLE only)
//   req_ready             unit is IDLE
//   stall                 hold EXE until the result has been written
//   done                  one-cycle pulse after any hi/lo write
//   hi, lo                architectural HI/LO registers
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | accept requests; MTHI/MTLO written directly
// MUL   | product pipeline filling; write {hi,lo} on last cycle
// DIV   | one restoring iteration per cycle, XLEN cycles
// FIX   | sign correction / special cases, write {hi,lo}

module exe_muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  input  logic [3:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            req_ready,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
`ifdef MDU_ACCUM_EN
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
`endif
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  function automatic logic op_is_mul(input logic [3:0] op);
`ifdef MDU_ACCUM_EN
    return (op == OP_MULT) || (op == OP_MULTU) || ((op >= OP_MADD) && (op <= OP_MSUBU));
`else
    return (op == OP_MULT) || (op == OP_MULTU);
`endif
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_signed(input logic [3:0] op);
`ifdef MDU_ACCUM_EN
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
`else
    return (op == OP_MULT) || (op == OP_DIV);
`endif
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] rem_q, rem_d, quot_q, quot_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic            done_q, done_d;

  // Shared datapath decode of the latched operation
  logic            a_neg, b_neg;
  logic [2*XLEN-1:0] a_ext, b_ext, prod_comb, mul_res, mul_wr;
  logic [XLEN-1:0] dvsr;
  logic [XLEN:0]   rem_shift, diff;
  logic            div_by_zero;
  logic [XLEN-1:0] fix_hi, fix_lo;

  assign a_neg = op_signed(op_q) & a_q[XLEN-1];
  assign b_neg = op_signed(op_q) & b_q[XLEN-1];

  // Sign/zero extension to 2*XLEN makes a single modular multiplier serve
  // both signed and unsigned products.
  assign a_ext     = {{XLEN{a_neg}}, a_q};
  assign b_ext     = {{XLEN{b_neg}}, b_q};
  assign prod_comb = a_ext * b_ext;

  generate
    if (MUL_STAGES == 1) begin : g_mul_comb
      assign mul_res = prod_comb;
    end else begin : g_mul_pipe
      logic [2*XLEN-1:0] pipe_q [MUL_STAGES-1];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < MUL_STAGES - 1; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= prod_comb;
          for (int i = 1; i < MUL_STAGES - 1; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign mul_res = pipe_q[MUL_STAGES-2];
    end
  endgenerate

`ifdef MDU_ACCUM_EN
  always_comb begin
    mul_wr = mul_res;
    case (op_q)
      OP_MADD, OP_MADDU: mul_wr = {hi_q, lo_q} + mul_res;
      OP_MSUB, OP_MSUBU: mul_wr = {hi_q, lo_q} - mul_res;
      default:           mul_wr = mul_res;
    endcase
  end
`else
  assign mul_wr = mul_res;
`endif

  // Restoring divider works on magnitudes; quotient shifts out the dividend
  // MSB-first while collecting quotient bits at the LSB.
  assign dvsr      = b_neg ? -b_q : b_q;
  assign rem_shift = {rem_q, quot_q[XLEN-1]};
  assign diff      = rem_shift - {1'b0, dvsr};

  assign div_by_zero = (b_q == '0);
  assign fix_lo = div_by_zero ? '1  : ((a_neg ^ b_neg) ? -quot_q : quot_q);
  assign fix_hi = div_by_zero ? a_q : (a_neg ? -rem_q : rem_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          if (req_op == OP_MTHI) begin
            hi_d   = req_a;
            done_d = 1'b1;
          end else if (req_op == OP_MTLO) begin
            lo_d   = req_a;
            done_d = 1'b1;
          end else if (op_is_mul(req_op) || op_is_div(req_op)) begin
            state_d = op_is_mul(req_op) ? MUL : DIV;
            op_d    = req_op;
            a_d     = req_a;
            b_d     = req_b;
            cnt_d   = '0;
            rem_d   = '0;
            quot_d  = (op_signed(req_op) && req_a[XLEN-1]) ? -req_a : req_a;
          end
        end
      end
      MUL: begin
        if (cnt_q == CW'(MUL_STAGES - 1)) begin
          {hi_d, lo_d} = mul_wr;
          done_d       = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DIV: begin
        if (!diff[XLEN]) begin
          rem_d  = diff[XLEN-1:0];
          quot_d = {quot_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d  = rem_shift[XLEN-1:0];
          quot_d = {quot_q[XLEN-2:0], 1'b0};
        end
        if (cnt_q == CW'(XLEN - 1)) state_d = FIX;
        else                        cnt_d   = cnt_q + CW'(1);
      end
      FIX: begin
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over any pending write, in every state.
    if (flush) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign stall     = (state_q != IDLE) ||
                     (req_valid && !flush && (op_is_mul(req_op) || op_is_div(req_op)));
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed testbench for exe_muldiv_unit (XLEN=32, MUL_STAGES=2).
module tb_exe_muldiv_unit;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        req_ready, stall, done;
  logic [31:0] hi, lo;

  int n_chk = 0;
  int n_bad = 0;

  exe_muldiv_unit #(.XLEN(32), .MUL_STAGES(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .stall(stall), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1. Presents one request, lets it be accepted, then
  // waits (bounded) for done. lat = edges from accept edge to write edge,
  // stalls = stall-high cycles after acceptance, rs = stall in request cycle.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int max_cyc, output int lat, output int stalls, output logic rs);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    #1 rs = stall;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 4'd0;
    lat = 0; stalls = 0;
    while (done !== 1'b1 && lat < max_cyc) begin
      if (stall) stalls++;
      @(posedge clk); #1;
      lat++;
    end
    chk("done_seen", {63'd0, done}, 64'd1);
  endtask

  int   lat, stalls, npulse;
  logic rs;

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_hi",    {32'd0, hi}, 64'd0);
    chk("rst_lo",    {32'd0, lo}, 64'd0);
    chk("rst_done",  {63'd0, done}, 64'd0);
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // MULT -2 * 3
    do_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 10, lat, stalls, rs);
    chk("mult_req_stall", {63'd0, rs}, 64'd1);
    chk("mult_lat",    64'(lat), 64'd2);
    chk("mult_stalls", 64'(stalls), 64'd2);
    chk("mult_hilo",   {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("mult_done_stall", {63'd0, stall}, 64'd0);
    chk("mult_done_ready", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    chk("mult_single_done", {63'd0, done}, 64'd0);

    // MULTU max * max
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, lat, stalls, rs);
    chk("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    // DIV -7 / 2
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 60, lat, stalls, rs);
    chk("div_lat",  64'(lat), 64'd33);
    chk("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    // DIVU 7 / 0
    do_op(OP_DIVU, 32'd7, 32'd0, 60, lat, stalls, rs);
    chk("divu0_lat",  64'(lat), 64'd33);
    chk("divu0_hilo", {hi, lo}, 64'h0000_0007_FFFF_FFFF);

    // DIV -5 / 0: hi keeps the signed dividend
    do_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, 60, lat, stalls, rs);
    chk("div0_hilo", {hi, lo}, 64'hFFFF_FFFB_FFFF_FFFF);

    // DIV MIN / -1
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 60, lat, stalls, rs);
    chk("divmin_lat",  64'(lat), 64'd33);
    chk("divmin_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

    // DIVU 100 / 7
    do_op(OP_DIVU, 32'd100, 32'd7, 60, lat, stalls, rs);
    chk("divu_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

    // MTHI / MTLO then MADDU
    do_op(OP_MTHI, 32'd1, 32'd0, 5, lat, stalls, rs);
    chk("mthi_req_stall", {63'd0, rs}, 64'd0);
    chk("mthi_lat", 64'(lat), 64'd0);
    do_op(OP_MTLO, 32'hFFFF_FFFF, 32'd0, 5, lat, stalls, rs);
    chk("mtlo_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFF);
`ifdef MDU_ACCUM_EN
    do_op(OP_MADDU, 32'd1, 32'd1, 10, lat, stalls, rs);
    chk("maddu_lat",  64'(lat), 64'd2);
    chk("maddu_hilo", {hi, lo}, 64'h0000_0002_0000_0000);
    do_op(OP_MSUB, 32'd1, 32'd1, 10, lat, stalls, rs);
    chk("msub_hilo",  {hi, lo}, 64'h0000_0001_FFFF_FFFF);
`else
    req_valid = 1'b1; req_op = OP_MADDU; req_a = 32'd1; req_b = 32'd1;
    #1 chk("maddu_nop_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 4'd0;
    chk("maddu_nop_ready", {63'd0, req_ready}, 64'd1);
    npulse = 0;
    repeat (4) begin
      if (done) npulse++;
      @(posedge clk); #1;
    end
    chk("maddu_nop_done", 64'(npulse), 64'd0);
    chk("maddu_nop_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFF);
    req_valid = 1'b1; req_op = OP_MSUB; req_a = 32'd1; req_b = 32'd1;
    #1 chk("msub_nop_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 4'd0;
`endif

    // Known hi/lo before flush tests
    do_op(OP_MTHI, 32'hAAAA_0000, 32'd0, 5, lat, stalls, rs);
    do_op(OP_MTLO, 32'h0000_BBBB, 32'd0, 5, lat, stalls, rs);

    // DIVU flushed at iteration 10
    req_valid = 1'b1; req_op = OP_DIVU; req_a = 32'd100; req_b = 32'd7;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 4'd0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_ready", {63'd0, req_ready}, 64'd1);
    npulse = 0;
    repeat (40) begin
      if (done) npulse++;
      @(posedge clk); #1;
    end
    chk("flush_no_done", 64'(npulse), 64'd0);
    chk("flush_hilo", {hi, lo}, 64'hAAAA_0000_0000_BBBB);

    // Request together with flush is dropped
    req_valid = 1'b1; req_op = OP_MULT; req_a = 32'd3; req_b = 32'd5; flush = 1'b1;
    #1 chk("flushreq_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    chk("flushreq_ready", {63'd0, req_ready}, 64'd1);
    req_op = OP_MTLO; req_a = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 4'd0; flush = 1'b0;
    npulse = 0;
    repeat (4) begin
      if (done) npulse++;
      @(posedge clk); #1;
    end
    chk("flushreq_no_done", 64'(npulse), 64'd0);
    chk("flushreq_hilo", {hi, lo}, 64'hAAAA_0000_0000_BBBB);

    // Reset in the middle of a MULT
    req_valid = 1'b1; req_op = OP_MULT; req_a = 32'd3; req_b = 32'd5;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 4'd0;
    rst = 1'b1;
    #1;
    chk("midrst_hilo",  {hi, lo}, 64'd0);
    chk("midrst_ready", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    npulse = 0;
    repeat (4) begin
      if (done) npulse++;
      @(posedge clk); #1;
    end
    chk("midrst_no_done", 64'(npulse), 64'd0);

    // Back-to-back: MULTU 3x5, then MTLO 9 accepted in the done cycle
    do_op(OP_MULTU, 32'd3, 32'd5, 10, lat, stalls, rs);
    chk("b2b_mul_lo", {32'd0, lo}, 64'd15);
    req_valid = 1'b1; req_op = OP_MTLO; req_a = 32'd9; req_b = 32'd0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 4'd0;
    chk("b2b_mtlo_lo",   {32'd0, lo}, 64'd9);
    chk("b2b_mtlo_done", {63'd0, done}, 64'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
